// File: rtl/instr_encoder.sv
// instr_encoder: packs field-level commands into RV32I words (LOAD, STORE,
// OP-IMM, OP, JAL, JALR) and streams them into sequential imem word addresses.
// One write per accepted command, one cycle after acceptance. Faults and
// program completion are sticky until reset.
module instr_encoder #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_class,
   input  logic [4:0]        cmd_rd,
   input  logic [4:0]        cmd_rs1,
   input  logic [4:0]        cmd_rs2,
   input  logic [2:0]        cmd_funct3,
   input  logic              cmd_f7b5,
   input  logic [20:0]       cmd_imm,
   input  logic              cmd_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   instr_count,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);

   // RUN accepts; DRAIN lets the final write complete before DONE/ERR
   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_DRAIN = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;
   localparam logic [1:0] S_ERR   = 2'd3;

   localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

   localparam logic [1:0] E_CLASS = 2'b01;
   localparam logic [1:0] E_RANGE = 2'b10;
   localparam logic [1:0] E_OVF   = 2'b11;

   typedef struct packed {
      logic [2:0]  cls;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic        f7b5;
      logic [20:0] imm;
   } cmd_t;

   cmd_t              cmd;
   logic [1:0]        state;
   logic              drain_ovf;
   logic              accept;
   logic              illegal;
   logic              range_ok;
   logic              imm_s12;
   logic [31:0]       enc;
   logic [ADDR_W-1:0] next_addr;

   assign cmd = {cmd_class, cmd_rd, cmd_rs1, cmd_rs2, cmd_funct3, cmd_f7b5, cmd_imm};

   assign cmd_ready = (state == S_RUN);
   assign accept    = cmd_valid & cmd_ready;

   // address the next accepted command lands on: a write in flight has
   // already claimed imem_addr
   assign next_addr = imem_we ? imem_addr + ADDR_W'(1) : imem_addr;

   // signed 12-bit immediate fits when bits 20..11 are a pure sign extension
   assign imm_s12 = (cmd.imm[20:11] == '0) || (cmd.imm[20:11] == '1);

   // field packing and per-class immediate range check
   always_comb begin
      enc      = '0;
      range_ok = 1'b1;
      illegal  = 1'b0;
      case (cmd.cls)
         3'd0: begin
            enc      = {cmd.imm[11:0], cmd.rs1, cmd.f3, cmd.rd, 7'h03};
            range_ok = imm_s12;
         end
         3'd1: begin
            enc      = {cmd.imm[11:5], cmd.rs2, cmd.rs1, cmd.f3, cmd.imm[4:0], 7'h23};
            range_ok = imm_s12;
         end
         3'd2: begin
            if (cmd.f3[1:0] == 2'b01) begin
               // SLLI/SRLI/SRAI: shamt in imm[4:0], instr[30] selects arithmetic
               enc      = {1'b0, cmd.f7b5, 5'b00000, cmd.imm[4:0], cmd.rs1, cmd.f3, cmd.rd, 7'h13};
               range_ok = (cmd.imm[20:5] == '0);
            end else begin
               enc      = {cmd.imm[11:0], cmd.rs1, cmd.f3, cmd.rd, 7'h13};
               range_ok = imm_s12;
            end
         end
         3'd3: begin
            enc = {1'b0, cmd.f7b5, 5'b00000, cmd.rs2, cmd.rs1, cmd.f3, cmd.rd, 7'h33};
         end
         3'd4: begin
            enc      = {cmd.imm[20], cmd.imm[10:1], cmd.imm[11], cmd.imm[19:12], cmd.rd, 7'h6F};
            range_ok = ~cmd.imm[0];
         end
         3'd5: begin
            enc      = {cmd.imm[11:0], cmd.rs1, 3'b000, cmd.rd, 7'h67};
            range_ok = imm_s12;
         end
         default: illegal = 1'b1;
      endcase
   end

   // write strobe, address/count bookkeeping and the run/drain/done/err FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_RUN;
         drain_ovf   <= 1'b0;
         imem_we     <= 1'b0;
         imem_addr   <= ADDR_BASE;
         imem_wdata  <= '0;
         instr_count <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
         err_code    <= 2'b00;
      end else begin
         imem_we <= 1'b0;
         if (imem_we) begin
            instr_count <= instr_count + (ADDR_W+1)'(1);
            // the top word is the last one ever written, so never wrap
            if (imem_addr != ADDR_MAX)
               imem_addr <= imem_addr + ADDR_W'(1);
         end
         case (state)
            S_RUN: begin
               if (accept) begin
                  if (illegal) begin
                     err      <= 1'b1;
                     err_code <= E_CLASS;
                     state    <= S_ERR;
                  end else if (!range_ok) begin
                     err      <= 1'b1;
                     err_code <= E_RANGE;
                     state    <= S_ERR;
                  end else begin
                     imem_we    <= 1'b1;
                     imem_wdata <= enc;
                     if (cmd_last) begin
                        state     <= S_DRAIN;
                        drain_ovf <= 1'b0;
                     end else if (next_addr == ADDR_MAX) begin
                        state     <= S_DRAIN;
                        drain_ovf <= 1'b1;
                     end
                  end
               end
            end
            S_DRAIN: begin
               if (drain_ovf) begin
                  err      <= 1'b1;
                  err_code <= E_OVF;
                  state    <= S_ERR;
               end else begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            default: state <= state;
         endcase
      end
   end

endmodule
